// File: rtl/led_trail_pwm.sv
// PWM-dimmed LED driver that turns a rotating one-hot pattern into a fading comet trail.
// Define LED_TRAIL_GAMMA_EN to compare a squared (gamma-corrected) level against the PWM counter.
module led_trail_pwm #(
    parameter int LED_N      = 12,
    parameter int PWM_W      = 8,
    parameter int DECAY_DIV  = 50_000,
    parameter int DECAY_STEP = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LED_N-1:0] pattern_in,
    input  logic             enable,
    output logic [LED_N-1:0] led_out,
    output logic             pwm_sync
);

    localparam int DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [PWM_W-1:0] LVL_MAX  = '1;
    localparam logic [PWM_W-1:0] STEP     = PWM_W'(DECAY_STEP);
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECAY_DIV - 1);

    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
    logic [PWM_W-1:0] level_q [LED_N];
    logic [PWM_W-1:0] level_d [LED_N];
    logic [LED_N-1:0] led_q, led_d;
    logic             sync_q, sync_d;
    logic             decay_tick;

    // Brightness value actually compared against the PWM counter.
    function automatic logic [PWM_W-1:0] shade(input logic [PWM_W-1:0] lvl);
`ifdef LED_TRAIL_GAMMA_EN
        logic [2*PWM_W-1:0] sq;
        sq = {{PWM_W{1'b0}}, lvl} * {{PWM_W{1'b0}}, lvl};
        return sq[2*PWM_W-1:PWM_W];
`else
        return lvl;
`endif
    endfunction

    assign decay_tick = (dec_cnt_q == DEC_LAST);

    always_comb begin
        pwm_cnt_d = '0;
        dec_cnt_d = '0;
        sync_d    = 1'b0;
        led_d     = '0;
        for (int i = 0; i < LED_N; i++) begin
            level_d[i] = '0;
        end
        if (enable) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            dec_cnt_d = decay_tick ? '0 : dec_cnt_q + 1'b1;
            sync_d    = (pwm_cnt_q == '0);
            for (int i = 0; i < LED_N; i++) begin
                // Full level bypasses the compare so a lit LED has no PWM gap.
                led_d[i] = (level_q[i] == LVL_MAX) || (shade(level_q[i]) > pwm_cnt_q);
                if (pattern_in[i]) begin
                    level_d[i] = LVL_MAX;
                end else if (decay_tick) begin
                    level_d[i] = (level_q[i] > STEP) ? level_q[i] - STEP : '0;
                end else begin
                    level_d[i] = level_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            dec_cnt_q <= '0;
            led_q     <= '0;
            sync_q    <= 1'b0;
            for (int i = 0; i < LED_N; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            dec_cnt_q <= dec_cnt_d;
            led_q     <= led_d;
            sync_q    <= sync_d;
            for (int i = 0; i < LED_N; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign led_out  = led_q;
    assign pwm_sync = sync_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: directed fade/sync scenarios plus randomized patterns,
// enable drops and async resets, all checked against an arithmetic reference model.
module tb_led_trail_pwm;

    localparam int LED_N      = 12;
    localparam int PWM_W      = 4;
    localparam int DECAY_DIV  = 16;
    localparam int DECAY_STEP = 4;
    localparam int PERIOD     = 1 << PWM_W;
    localparam int MAXL       = PERIOD - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [LED_N-1:0] pattern_in = '0;
    logic [LED_N-1:0] led_out;
    logic             pwm_sync;

    int n_checks = 0;
    int n_errors = 0;

    int               m_pwm;
    int               m_dec;
    int               m_level [LED_N];
    logic [LED_N-1:0] m_led;
    logic             m_sync;

    always #5 clk = ~clk;

    led_trail_pwm #(
        .LED_N(LED_N), .PWM_W(PWM_W), .DECAY_DIV(DECAY_DIV), .DECAY_STEP(DECAY_STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pattern_in(pattern_in), .enable(enable),
        .led_out(led_out), .pwm_sync(pwm_sync)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int l);
`ifdef LED_TRAIL_GAMMA_EN
        return (l * l) >> PWM_W;
`else
        return l;
`endif
    endfunction

    task automatic model_clear();
        m_pwm  = 0;
        m_dec  = 0;
        m_led  = '0;
        m_sync = 1'b0;
        for (int i = 0; i < LED_N; i++) m_level[i] = 0;
    endtask

    // One clock edge of the reference: outputs reflect the state before the edge.
    task automatic model_edge();
        logic [LED_N-1:0] nl;
        bit               tick;
        if (!rst_n || !enable) begin
            model_clear();
            return;
        end
        tick = (m_dec == DECAY_DIV - 1);
        for (int i = 0; i < LED_N; i++)
            nl[i] = (m_level[i] == MAXL) || (eff(m_level[i]) > m_pwm);
        m_led  = nl;
        m_sync = (m_pwm == 0);
        for (int i = 0; i < LED_N; i++) begin
            if (pattern_in[i])  m_level[i] = MAXL;
            else if (tick)      m_level[i] = (m_level[i] > DECAY_STEP) ? m_level[i] - DECAY_STEP : 0;
        end
        m_pwm = (m_pwm + 1) % PERIOD;
        m_dec = (m_dec + 1) % DECAY_DIV;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("led_out", 32'(led_out), 32'(m_led));
        chk("pwm_sync", 32'(pwm_sync), 32'(m_sync));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        model_clear();
        chk("async_rst_led", 32'(led_out), 32'd0);
        chk("async_rst_sync", 32'(pwm_sync), 32'd0);
        cycle();
        rst_n = 1'b1;
    endtask

    function automatic logic [LED_N-1:0] sched(input int n);
        if (n < 16)       return 12'h001;
        else if (n < 142) return 12'h002;
        else if (n == 142) return 12'h000;
        else if (n == 143) return 12'h002;
        else               return 12'h000;
    endfunction

    initial begin
        int               cnt0 [8];
        int               cnt1a, cnt1b;
        int               exp_fade [6];
        int               exp_l11;
        logic [LED_N-1:0] pat;
        int               hold;

`ifdef LED_TRAIL_GAMMA_EN
        exp_fade = '{16, 7, 3, 0, 0, 0};
        exp_l11  = 7;
`else
        exp_fade = '{16, 11, 7, 3, 0, 0};
        exp_l11  = 11;
`endif
        for (int j = 0; j < 8; j++) cnt0[j] = 0;
        cnt1a = 0;
        cnt1b = 0;

        // Reset held with enable and pattern active: outputs must stay low.
        model_clear();
        enable     = 1'b1;
        pattern_in = '1;
        #12;
        chk("reset_led", 32'(led_out), 32'd0);
        chk("reset_sync", 32'(pwm_sync), 32'd0);
        cycle();
        cycle();
        rst_n      = 1'b1;
        enable     = 1'b0;
        pattern_in = '0;
        cycle();

        enable     = 1'b1;
        pattern_in = sched(0);
        for (int k = 0; k < 176; k++) begin
            cycle();
            chk("sync_phase", 32'(pwm_sync), 32'(k % 16 == 0));
            if (k == 0) chk("latency_k0", 32'(led_out[0]), 32'd0);
            if (k == 1) chk("latency_k1", 32'(led_out[0]), 32'd1);
            if (k >= 1 && k <= 16) chk("single_led", 32'(led_out), 32'h001);
            if (k >= 17 && k <= 143) chk("bit1_on", 32'(led_out[1]), 32'd1);
            if (k >= 16 && k < 112) cnt0[k / 16] += int'(led_out[0]);
            if (k >= 144 && k < 160) cnt1a += int'(led_out[1]);
            if (k >= 160 && k < 176) cnt1b += int'(led_out[1]);
            pattern_in = sched(k + 1);
        end
        for (int j = 1; j <= 6; j++) chk($sformatf("fade_period%0d", j), 32'(cnt0[j]), 32'(exp_fade[j-1]));
        chk("tick_collision_full", 32'(cnt1a), 32'd16);
        chk("after_collision_l11", 32'(cnt1b), 32'(exp_l11));

        // Drop enable mid-fade, then re-enable dark.
        enable = 1'b0;
        cycle();
        chk("disable_blank", 32'(led_out), 32'd0);
        cycle();
        enable     = 1'b1;
        pattern_in = '0;
        cycle();
        chk("reenable_sync", 32'(pwm_sync), 32'd1);
        for (int k = 0; k < 40; k++) begin
            cycle();
            chk("reenable_dark", 32'(led_out), 32'd0);
        end

        // Async reset in the middle of a fade.
        pattern_in = 12'h0F0;
        repeat (5) cycle();
        pattern_in = '0;
        repeat (20) cycle();
        pulse_reset();
        repeat (40) begin
            cycle();
            chk("no_residual_glow", 32'(led_out), 32'd0);
        end

        // Randomized running-light traffic.
        pat  = 12'h001;
        hold = 0;
        for (int it = 0; it < 3000; it++) begin
            if (hold == 0) begin
                pat  = {pat[LED_N-2:0], pat[LED_N-1]};
                hold = $urandom_range(1, 40);
            end
            hold--;
            pattern_in = ($urandom_range(0, 15) == 0) ? LED_N'($urandom) : pat;
            if ($urandom_range(0, 299) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            if ($urandom_range(0, 999) == 0) pulse_reset();
            else cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
